sparse_map_encoder: RTL and testbench
=====================================

Name: sparse_map_encoder

Overview:
- Parametrised next-generation sparse-map encoder in the PRE (pre-processing) path.
- Collects a group of activation pixels from the upstream stream and builds a per-pixel non-zero bitmap (sparsity map).
- Packs the non-zero pixels densely, then writes two streams through the PRE memory-port handshake: packed pixels first, then the map.
- Generalises pixel width, lanes per beat, beats per group and memory width; adds group counting, a done pulse and all-zero-group skipping.

Parameters:
- PX_W, 8: pixel width in bits.
- LANES, 8: pixels per input beat; din width = LANES*PX_W.
- BEATS, 2: beats per group; G = LANES*BEATS pixels and G map bits per group.
- MEM_W, 32: memory data word width. Must be a multiple of PX_W. G*PX_W and G must each be ≤ 256*MEM_W.
- ADDR_W, 32: byte address width.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; loads config and begins a frame.
- cfg_px_base  in  ADDR_W  byte base address of the packed-pixel region.
- cfg_map_base  in  ADDR_W  byte base address of the map region.
- cfg_num_groups  in  16  groups per frame; 0 means done immediately.
- din  in  LANES*PX_W  input beat; lane i occupies bits [i*PX_W +: PX_W].
- din_vld  in  1  beat valid.
- din_rdy  out  1  beat accepted when din_vld & din_rdy.
- mem_wr_buf  out  1  pushes mem_wdata into the controller write buffer this cycle.
- mem_wdata  out  MEM_W  write data.
- mem_req  out  1  write request.
- mem_cmd  out  4  command; 4'h1 = burst write.
- mem_addr  out  ADDR_W  burst start byte address.
- mem_len  out  8  burst length in words, minus 1.
- mem_gnt  in  1  one-cycle grant ending the request.
- busy  out  1  high from start until the done pulse.
- done  out  1  one-cycle pulse after the last map write is granted.

Behaviour:
- Reset: all outputs 0, state IDLE, pointers 0.
- IDLE:
  - start loads px_ptr = cfg_px_base, map_ptr = cfg_map_base, grp_cnt = cfg_num_groups.
  - If grp_cnt = 0, pulse done next cycle; otherwise go to COLLECT.
  - start outside IDLE is ignored.
- COLLECT:
  - din_rdy = 1 only in this state.
  - Each accepted beat goes to beat slot beat_cnt, pixel index = beat_cnt*LANES + lane.
  - After BEATS accepted beats, go to ENCODE.
  - A stall on din_vld may be arbitrarily long.
- ENCODE (1 cycle, registered):
  - map bit k = (pixel k != 0).
  - nnz = popcount(map).
  - Packed buffer: non-zero pixels in ascending k, the first one at bit 0; remaining bits zero.
  - px_words = ceil(nnz*PX_W/MEM_W).
  - If nnz = 0, go to SM_BUF; otherwise go to PX_BUF.
- PX_BUF:
  - mem_wr_buf is high for exactly px_words consecutive cycles.
  - mem_wdata = packed word 0, 1, … (low word first).
- PX_REQ:
  - Drive mem_req = 1, mem_cmd = 4'h1, mem_addr = px_ptr, mem_len = px_words-1.
  - All four are held stable until the mem_gnt cycle and dropped the cycle after.
  - On grant, px_ptr += px_words*(MEM_W/8); go to SM_BUF.
- SM_BUF / SM_REQ:
  - Same sequence for map_words = ceil(G/MEM_W) words, zero-padded, at map_ptr.
  - On grant, map_ptr += map_words*(MEM_W/8) and grp_cnt -= 1.
  - Then go to COLLECT, or, if grp_cnt reaches 0, pulse done and go to IDLE.
- Pointer arithmetic wraps modulo 2^ADDR_W; no overflow flag.
- mem_gnt outside a REQ state is ignored.
- rst asserted mid-operation aborts immediately and clears all state. Any partially pushed write-buffer data is the controller's responsibility.

Optional Feature:
- SME_ZERO_THRESH_EN defined:
  - Adds input port cfg_thresh (PX_W bits), latched on start.
  - A pixel is non-zero only when it is strictly greater than cfg_thresh (unsigned compare).
  - Pixels at or below the threshold get map bit 0 and are not packed.
- Undefined: the port is absent and the compare is != 0.

Decomposition:
- Package sme_pkg holds:
  - State enum: IDLE, COLLECT, ENCODE, PX_BUF, PX_REQ, SM_BUF, SM_REQ.
  - CMD_WR = 4'h1.
  - Derived constants: G, map_words, maximum px words.
- One sub-module, sme_packer: combinational G-input compaction (prefix-count select) producing the map, nnz and the packed vector. It is registered by the parent in ENCODE.

Test Plan:
- Mixed group (defaults): beat0 = 64'h0000_0300_0000_0005, beat1 = 0, px base 0x1000, map base 0x2000 → px burst 32'h0000_0305 at 0x1000 with len 0; map burst 32'h0000_0021 at 0x2000; done.
- All-zero group → no px burst; map burst 32'h0 only; px_ptr unchanged.
- Dense group of 16 pixels 0x01..0x10 → 4 px words starting 32'h0403_0201 (len 3), then map 32'h0000_FFFF.
- Three groups, each with nnz = 5, mem_gnt delayed 7 cycles → px addresses base, +8, +16; map addresses +0, +4, +8; request signals held stable throughout each wait.
- rst raised in PX_REQ → all outputs 0 within the same cycle; a new start runs cleanly from the new bases.
- With SME_ZERO_THRESH_EN, cfg_thresh = 3, pixels {3, 4, 0, 9, …} → map bits 0b1010, packed 32'h0000_0904.

Source files
------------

// File: rtl/sparse_map_encoder_pkg.sv
// ---------------------------------------------------------------------------
// sme_pkg -- shared types and helpers for sparse_map_encoder.
//
// Contents:
//   sme_state_t    : controller states (IDLE .. SM_REQ)
//   CMD_WR         : memory-port burst write command
//   ceil_div()     : integer ceiling division used for word counts
//   group_px()     : G, pixels (and map bits) per group
//   map_words()    : words needed to store one group's map
//   max_px_words() : words needed for a fully dense group
//   DEF_*          : derived constants for the default parameter set
// ---------------------------------------------------------------------------
package sme_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        ENCODE  = 3'd2,
        PX_BUF  = 3'd3,
        PX_REQ  = 3'd4,
        SM_BUF  = 3'd5,
        SM_REQ  = 3'd6
    } sme_state_t;

    localparam logic [3:0] CMD_WR = 4'h1;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    function automatic int group_px(input int lanes, input int beats);
        return lanes * beats;
    endfunction

    function automatic int map_words(input int g, input int mem_w);
        return ceil_div(g, mem_w);
    endfunction

    function automatic int max_px_words(input int g, input int px_w, input int mem_w);
        return ceil_div(g * px_w, mem_w);
    endfunction

    localparam int DEF_G            = group_px(8, 2);
    localparam int DEF_MAP_WORDS    = map_words(DEF_G, 32);
    localparam int DEF_MAX_PX_WORDS = max_px_words(DEF_G, 8, 32);

endpackage

// File: rtl/sparse_map_encoder_if.sv
// ---------------------------------------------------------------------------
// sparse_map_encoder_if -- upstream pixel stream plus PRE memory-port write
// handshake for sparse_map_encoder.
//
// Signals:
//   din/din_vld/din_rdy : pixel beats, accepted when din_vld & din_rdy
//   mem_wr_buf/mem_wdata: one write-buffer word per cycle
//   mem_req/mem_cmd/mem_addr/mem_len : burst request, held until mem_gnt
//   mem_gnt             : one-cycle grant from the memory controller
//
// Modports:
//   master : the encoder (consumes pixels, drives the memory port)
//   slave  : the environment (pixel source + memory controller)
// ---------------------------------------------------------------------------
interface sparse_map_encoder_if #(
    parameter int PX_W   = 8,
    parameter int LANES  = 8,
    parameter int MEM_W  = 32,
    parameter int ADDR_W = 32
);
    logic [LANES*PX_W-1:0] din;
    logic                  din_vld;
    logic                  din_rdy;
    logic                  mem_wr_buf;
    logic [MEM_W-1:0]      mem_wdata;
    logic                  mem_req;
    logic [3:0]            mem_cmd;
    logic [ADDR_W-1:0]     mem_addr;
    logic [7:0]            mem_len;
    logic                  mem_gnt;

    modport master (
        input  din, din_vld, mem_gnt,
        output din_rdy, mem_wr_buf, mem_wdata, mem_req, mem_cmd, mem_addr, mem_len
    );

    modport slave (
        output din, din_vld, mem_gnt,
        input  din_rdy, mem_wr_buf, mem_wdata, mem_req, mem_cmd, mem_addr, mem_len
    );
endinterface

// File: rtl/sparse_map_encoder_packer.sv
// ---------------------------------------------------------------------------
// sme_packer -- combinational G-input sparse compaction.
//
// Ports:
//   pix        in  G*PX_W  group pixels, pixel k at [k*PX_W +: PX_W]
//   thresh     in  PX_W    a pixel counts as non-zero when pix > thresh
//   map        out G       per-pixel non-zero bitmap
//   nnz        out NNZ_W   popcount of map
//   packed_px  out OUT_W   non-zero pixels in ascending k, first at bit 0,
//                          upper bits zero
//
// Each non-zero pixel lands in the slot given by the count of non-zero
// pixels below it (running prefix count).
// ---------------------------------------------------------------------------
module sme_packer #(
    parameter int PX_W  = 8,
    parameter int G     = 16,
    parameter int OUT_W = 128,
    parameter int NNZ_W = $clog2(G + 1)
) (
    input  logic [G*PX_W-1:0] pix,
    input  logic [PX_W-1:0]   thresh,
    output logic [G-1:0]      map,
    output logic [NNZ_W-1:0]  nnz,
    output logic [OUT_W-1:0]  packed_px
);

    for (genvar gi = 0; gi < G; gi++) begin : g_map
        assign map[gi] = (pix[gi*PX_W +: PX_W] > thresh);
    end

    always_comb begin
        logic [NNZ_W-1:0] cnt;
        cnt       = '0;
        packed_px = '0;
        for (int k = 0; k < G; k++) begin
            if (map[k]) begin
                packed_px[cnt*PX_W +: PX_W] = pix[k*PX_W +: PX_W];
                cnt = cnt + NNZ_W'(1);
            end
        end
        nnz = cnt;
    end

endmodule

// File: rtl/sparse_map_encoder.sv
// ---------------------------------------------------------------------------
// sparse_map_encoder -- PRE-path sparse-map encoder.
//
// Collects BEATS beats of LANES pixels, builds a non-zero bitmap, packs the
// non-zero pixels densely and writes two bursts per group through the
// memory port: packed pixels (skipped when the group is all zero), then the
// zero-padded map. Pointers advance per group and wrap modulo 2^ADDR_W.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   start               one-cycle pulse, loads config in IDLE
//   cfg_px_base         byte base of packed-pixel region
//   cfg_map_base        byte base of map region
//   cfg_num_groups      groups per frame (0 = done immediately)
//   cfg_thresh          only with SME_ZERO_THRESH_EN: pixels <= thresh are
//                       treated as zero
//   bus                 sparse_map_encoder_if.master (pixel stream + memory)
//   busy                high from start up to and including the done pulse
//   done                one-cycle pulse at end of frame
//
// Build option: define SME_ZERO_THRESH_EN to add cfg_thresh.
// ---------------------------------------------------------------------------
module sparse_map_encoder
    import sme_pkg::*;
#(
    parameter int PX_W   = 8,
    parameter int LANES  = 8,
    parameter int BEATS  = 2,
    parameter int MEM_W  = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_px_base,
    input  logic [ADDR_W-1:0] cfg_map_base,
    input  logic [15:0]       cfg_num_groups,
`ifdef SME_ZERO_THRESH_EN
    input  logic [PX_W-1:0]   cfg_thresh,
`endif
    sparse_map_encoder_if.master bus,
    output logic              busy,
    output logic              done
);

    localparam int G            = group_px(LANES, BEATS);
    localparam int BEAT_PX_W    = LANES * PX_W;
    localparam int PPW          = MEM_W / PX_W;
    localparam int MAP_WORDS    = map_words(G, MEM_W);
    localparam int MAX_PX_WORDS = max_px_words(G, PX_W, MEM_W);
    localparam int PK_W         = MAX_PX_WORDS * MEM_W;
    localparam int MAP_PAD_W    = MAP_WORDS * MEM_W;
    localparam int NNZ_W        = $clog2(G + 1);
    localparam int BEAT_W       = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WORD_BYTES   = MEM_W / 8;

    sme_state_t state_reg, state_next;

    logic [BEAT_W-1:0]    beat_cnt_reg;
    logic [BEAT_PX_W-1:0] beat_buf_reg [BEATS];
    logic [G*PX_W-1:0]    pix_flat;
    logic [MAP_PAD_W-1:0] map_reg;
    logic [PK_W-1:0]      packed_reg;
    logic [8:0]           px_words_reg;
    logic [8:0]           word_idx_reg;
    logic [ADDR_W-1:0]    px_ptr_reg;
    logic [ADDR_W-1:0]    map_ptr_reg;
    logic [15:0]          grp_cnt_reg;
    logic                 busy_reg;
    logic                 done_reg;
    logic [PX_W-1:0]      thresh_use;

    logic [G-1:0]         map_c;
    logic [NNZ_W-1:0]     nnz_c;
    logic [PK_W-1:0]      packed_c;
    logic [8:0]           px_words_c;

`ifdef SME_ZERO_THRESH_EN
    logic [PX_W-1:0] thresh_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            thresh_reg <= '0;
        end else if (state_reg == IDLE && start) begin
            thresh_reg <= cfg_thresh;
        end
    end

    assign thresh_use = thresh_reg;
`else
    // Strictly-greater-than zero is the same test as non-zero.
    assign thresh_use = '0;
`endif

    // Beat slot b holds pixels b*LANES .. b*LANES+LANES-1.
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_flat
        assign pix_flat[gi*BEAT_PX_W +: BEAT_PX_W] = beat_buf_reg[gi];
    end

    sme_packer #(
        .PX_W  (PX_W),
        .G     (G),
        .OUT_W (PK_W),
        .NNZ_W (NNZ_W)
    ) u_packer (
        .pix       (pix_flat),
        .thresh    (thresh_use),
        .map       (map_c),
        .nnz       (nnz_c),
        .packed_px (packed_c)
    );

    assign px_words_c = 9'((32'(nnz_c) + PPW - 1) / PPW);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        bus.din_rdy     = 1'b0;
        bus.mem_wr_buf  = 1'b0;
        bus.mem_wdata   = '0;
        bus.mem_req     = 1'b0;
        bus.mem_cmd     = 4'h0;
        bus.mem_addr    = '0;
        bus.mem_len     = 8'h00;

        case (state_reg)
            IDLE: begin
                if (start && cfg_num_groups != 16'd0) state_next = COLLECT;
            end
            COLLECT: begin
                bus.din_rdy = 1'b1;
                if (bus.din_vld && beat_cnt_reg == BEAT_W'(BEATS - 1)) state_next = ENCODE;
            end
            ENCODE: begin
                state_next = (nnz_c == '0) ? SM_BUF : PX_BUF;
            end
            PX_BUF: begin
                bus.mem_wr_buf = 1'b1;
                bus.mem_wdata  = packed_reg[word_idx_reg*MEM_W +: MEM_W];
                if (word_idx_reg == px_words_reg - 9'd1) state_next = PX_REQ;
            end
            PX_REQ: begin
                bus.mem_req  = 1'b1;
                bus.mem_cmd  = CMD_WR;
                bus.mem_addr = px_ptr_reg;
                bus.mem_len  = 8'(px_words_reg - 9'd1);
                if (bus.mem_gnt) state_next = SM_BUF;
            end
            SM_BUF: begin
                bus.mem_wr_buf = 1'b1;
                bus.mem_wdata  = map_reg[word_idx_reg*MEM_W +: MEM_W];
                if (word_idx_reg == 9'(MAP_WORDS - 1)) state_next = SM_REQ;
            end
            SM_REQ: begin
                bus.mem_req  = 1'b1;
                bus.mem_cmd  = CMD_WR;
                bus.mem_addr = map_ptr_reg;
                bus.mem_len  = 8'(MAP_WORDS - 1);
                if (bus.mem_gnt) state_next = (grp_cnt_reg == 16'd1) ? IDLE : COLLECT;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt_reg <= '0;
            for (int b = 0; b < BEATS; b++) beat_buf_reg[b] <= '0;
            map_reg      <= '0;
            packed_reg   <= '0;
            px_words_reg <= '0;
            word_idx_reg <= '0;
            px_ptr_reg   <= '0;
            map_ptr_reg  <= '0;
            grp_cnt_reg  <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            // busy covers the done cycle, then drops unless a new frame starts.
            if (done_reg) busy_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        px_ptr_reg   <= cfg_px_base;
                        map_ptr_reg  <= cfg_map_base;
                        grp_cnt_reg  <= cfg_num_groups;
                        beat_cnt_reg <= '0;
                        busy_reg     <= 1'b1;
                        if (cfg_num_groups == 16'd0) done_reg <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (bus.din_vld) begin
                        for (int b = 0; b < BEATS; b++) begin
                            if (beat_cnt_reg == BEAT_W'(b)) beat_buf_reg[b] <= bus.din;
                        end
                        beat_cnt_reg <= (beat_cnt_reg == BEAT_W'(BEATS - 1)) ?
                                        '0 : beat_cnt_reg + BEAT_W'(1);
                    end
                end
                ENCODE: begin
                    map_reg      <= MAP_PAD_W'(map_c);
                    packed_reg   <= packed_c;
                    px_words_reg <= px_words_c;
                    word_idx_reg <= '0;
                end
                PX_BUF: begin
                    word_idx_reg <= (word_idx_reg == px_words_reg - 9'd1) ?
                                    '0 : word_idx_reg + 9'd1;
                end
                PX_REQ: begin
                    if (bus.mem_gnt) begin
                        px_ptr_reg <= px_ptr_reg +
                                      ADDR_W'(px_words_reg) * ADDR_W'(WORD_BYTES);
                    end
                end
                SM_BUF: begin
                    word_idx_reg <= (word_idx_reg == 9'(MAP_WORDS - 1)) ?
                                    '0 : word_idx_reg + 9'd1;
                end
                SM_REQ: begin
                    if (bus.mem_gnt) begin
                        map_ptr_reg <= map_ptr_reg + ADDR_W'(MAP_WORDS * WORD_BYTES);
                        grp_cnt_reg <= grp_cnt_reg - 16'd1;
                        if (grp_cnt_reg == 16'd1) done_reg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_sparse_map_encoder.sv
// ---------------------------------------------------------------------------
// tb_sparse_map_encoder -- self-checking bench for sparse_map_encoder with
// default parameters (8-bit pixels, 8 lanes, 2 beats, 32-bit words).
// A queue-based reference model derives every expected burst and word.
// Define SME_ZERO_THRESH_EN to exercise the threshold build.
// ---------------------------------------------------------------------------
module tb_sparse_map_encoder;

    localparam int PX_W   = 8;
    localparam int LANES  = 8;
    localparam int BEATS  = 2;
    localparam int MEM_W  = 32;
    localparam int ADDR_W = 32;
    localparam int G      = LANES * BEATS;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] cfg_px_base;
    logic [ADDR_W-1:0] cfg_map_base;
    logic [15:0]       cfg_num_groups;
    logic [PX_W-1:0]   cfg_thresh;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    sparse_map_encoder_if #(.PX_W(PX_W), .LANES(LANES), .MEM_W(MEM_W), .ADDR_W(ADDR_W)) sif ();

    sparse_map_encoder #(
        .PX_W(PX_W), .LANES(LANES), .BEATS(BEATS), .MEM_W(MEM_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .cfg_px_base    (cfg_px_base),
        .cfg_map_base   (cfg_map_base),
        .cfg_num_groups (cfg_num_groups),
`ifdef SME_ZERO_THRESH_EN
        .cfg_thresh     (cfg_thresh),
`endif
        .bus            (sif),
        .busy           (busy),
        .done           (done)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [3:0]  cmd;
    } burst_t;

    burst_t      got_b[$], exp_b[$];
    logic [31:0] got_w[$], exp_w[$];
    int          words_since = 0;
    int          gnt_delay   = 0;
    bit          gnt_block   = 1'b0;
    logic [31:0] exp_px_ptr, exp_map_ptr;
    logic [7:0]  model_thr   = 8'h00;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory controller: captures pushed words and bursts, grants after
    // gnt_delay extra cycles, and checks that the request is held steady.
    initial begin : collector
        bit     waiting;
        bit     stable;
        int     wait_cnt;
        burst_t cap;
        waiting     = 1'b0;
        stable      = 1'b1;
        wait_cnt    = 0;
        cap         = '0;
        sif.mem_gnt = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                waiting     = 1'b0;
                sif.mem_gnt = 1'b0;
                words_since = 0;
                continue;
            end
            if (sif.mem_gnt) begin
                sif.mem_gnt = 1'b0;
                check("req_drop_after_gnt", sif.mem_req, 1'b0);
                check("req_held_stable", stable, 1'b1);
                got_b.push_back(cap);
                waiting = 1'b0;
            end
            if (sif.mem_wr_buf) begin
                got_w.push_back(sif.mem_wdata);
                words_since++;
            end
            if (sif.mem_req) begin
                if (!waiting) begin
                    cap      = '{sif.mem_addr, sif.mem_len, sif.mem_cmd};
                    waiting  = 1'b1;
                    wait_cnt = 0;
                    stable   = 1'b1;
                    check("words_before_req", 64'(words_since), 64'(int'(sif.mem_len) + 1));
                    words_since = 0;
                end else begin
                    if ({sif.mem_addr, sif.mem_len, sif.mem_cmd} !== cap) stable = 1'b0;
                    wait_cnt++;
                end
                if (!gnt_block && wait_cnt >= gnt_delay) sif.mem_gnt = 1'b1;
            end
        end
    end

    // Reference model: one group's bursts from the encoding rules.
    task automatic model_group(input logic [7:0] px [G]);
        logic [7:0]  nz[$];
        logic [31:0] w;
        logic [31:0] m;
        int          nwords;
        m = '0;
        for (int k = 0; k < G; k++) begin
            if (px[k] > model_thr) begin
                nz.push_back(px[k]);
                m[k] = 1'b1;
            end
        end
        nwords = (nz.size() + 3) / 4;
        if (nwords > 0) begin
            exp_b.push_back('{exp_px_ptr, 8'(nwords - 1), 4'h1});
            for (int i = 0; i < nwords; i++) begin
                w = '0;
                for (int j = 0; j < 4; j++) begin
                    if (i*4 + j < nz.size()) w[j*8 +: 8] = nz[i*4 + j];
                end
                exp_w.push_back(w);
            end
            exp_px_ptr = exp_px_ptr + 32'(nwords * 4);
        end
        exp_b.push_back('{exp_map_ptr, 8'h00, 4'h1});
        exp_w.push_back(m);
        exp_map_ptr = exp_map_ptr + 32'd4;
    endtask

    task automatic start_frame(input logic [31:0] pb, input logic [31:0] mb, input logic [15:0] n);
        @(negedge clk);
        cfg_px_base    = pb;
        cfg_map_base   = mb;
        cfg_num_groups = n;
        start          = 1'b1;
        exp_px_ptr     = pb;
        exp_map_ptr    = mb;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_group(input logic [7:0] px [G], input int max_stall);
        logic [63:0] beat;
        int          n;
        for (int b = 0; b < BEATS; b++) begin
            for (int l = 0; l < LANES; l++) beat[l*8 +: 8] = px[b*LANES + l];
            repeat ($urandom_range(0, max_stall)) @(negedge clk);
            sif.din     = beat;
            sif.din_vld = 1'b1;
            n = 0;
            while (!sif.din_rdy && n <= 2000) begin
                @(negedge clk);
                n++;
            end
            if (n > 2000) begin
                checks++;
                failures++;
                $display("FAIL din_rdy_timeout: got 0 expected 1 within 2000 cycles");
            end
            @(negedge clk);
            sif.din_vld = 1'b0;
        end
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (!done && n <= limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n > limit) begin
            failures++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", limit);
        end
        check("busy_at_done", busy, 1'b1);
        @(negedge clk);
        check("done_one_cycle", done, 1'b0);
        check("busy_after_done", busy, 1'b0);
    endtask

    task automatic compare_frame(input string tag);
        check({tag, "_n_bursts"}, 64'(got_b.size()), 64'(exp_b.size()));
        for (int i = 0; i < exp_b.size() && i < got_b.size(); i++)
            check({tag, "_burst"}, 64'(got_b[i]), 64'(exp_b[i]));
        check({tag, "_n_words"}, 64'(got_w.size()), 64'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && i < got_w.size(); i++)
            check({tag, "_word"}, got_w[i], exp_w[i]);
        got_b.delete(); exp_b.delete(); got_w.delete(); exp_w.delete();
    endtask

    task automatic beats_to_px(input logic [63:0] b0, input logic [63:0] b1, output logic [7:0] px [G]);
        for (int l = 0; l < LANES; l++) begin
            px[l]         = b0[l*8 +: 8];
            px[LANES + l] = b1[l*8 +: 8];
        end
    endtask

    typedef struct {
        logic [63:0] b0;
        logic [63:0] b1;
        int          px_bursts;
        logic [7:0]  px_len;
        logic [31:0] px_w0;
        logic [31:0] map_w;
    } vec_t;

    vec_t        vecs [3];
    logic [7:0]  px [G];

    initial begin
        rst            = 1'b1;
        start          = 1'b0;
        cfg_px_base    = '0;
        cfg_map_base   = '0;
        cfg_num_groups = '0;
        cfg_thresh     = '0;
        sif.din        = '0;
        sif.din_vld    = 1'b0;

        vecs[0] = '{64'h0000_0300_0000_0005, 64'h0, 1, 8'd0, 32'h0000_0305, 32'h0000_0021};
        vecs[1] = '{64'h0, 64'h0, 0, 8'd0, 32'h0, 32'h0000_0000};
        vecs[2] = '{64'h0807_0605_0403_0201, 64'h100F_0E0D_0C0B_0A09, 1, 8'd3,
                    32'h0403_0201, 32'h0000_FFFF};

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_din_rdy", sif.din_rdy, 1'b0);
        check("rst_mem_req", sif.mem_req, 1'b0);
        check("rst_mem_wr_buf", sif.mem_wr_buf, 1'b0);
        check("rst_mem_bus", {sif.mem_wdata, sif.mem_addr}, 64'h0);
        rst = 1'b0;

        // Table-driven single-group frames.
        for (int v = 0; v < 3; v++) begin
            start_frame(32'h1000, 32'h2000, 16'd1);
            beats_to_px(vecs[v].b0, vecs[v].b1, px);
            send_group(px, 0);
            wait_done(200);
            check("tbl_n_bursts", 64'(got_b.size()), 64'(vecs[v].px_bursts + 1));
            if (vecs[v].px_bursts == 1) begin
                check("tbl_px_addr", got_b[0].addr, 32'h1000);
                check("tbl_px_len", got_b[0].len, vecs[v].px_len);
                check("tbl_px_cmd", got_b[0].cmd, 4'h1);
                check("tbl_px_w0", got_w[0], vecs[v].px_w0);
            end
            check("tbl_map_addr", got_b[vecs[v].px_bursts].addr, 32'h2000);
            check("tbl_map_word", got_w[got_w.size() - 1], vecs[v].map_w);
            got_b.delete(); got_w.delete();
            $display("table vector %0d applied", v);
        end

        // Zero groups: done on the cycle after start, no bursts.
        start_frame(32'h3000, 32'h4000, 16'd0);
        check("zero_grp_done_next", done, 1'b1);
        wait_done(5);
        compare_frame("zero_grp");
        $display("zero-group frame");

        // All-zero group then mixed group: px pointer must not move.
        start_frame(32'h1000, 32'h2000, 16'd2);
        beats_to_px(64'h0, 64'h0, px);
        model_group(px);
        send_group(px, 2);
        beats_to_px(64'h0000_0300_0000_0005, 64'h0, px);
        model_group(px);
        send_group(px, 2);
        wait_done(300);
        check("skip_px_addr", exp_b[1].addr, 32'h1000);
        compare_frame("skip");
        $display("zero-then-mixed frame");

        // Three groups of nnz=5 with a 7-cycle grant delay.
        gnt_delay = 7;
        start_frame(32'h0000_8000, 32'h0000_9000, 16'd3);
        for (int g = 0; g < 3; g++) begin
            int cnt;
            for (int k = 0; k < G; k++) px[k] = 8'h00;
            cnt = 0;
            while (cnt < 5) begin
                int k;
                k = $urandom_range(0, G - 1);
                if (px[k] == 8'h00) begin
                    px[k] = 8'($urandom_range(1, 255));
                    cnt++;
                end
            end
            model_group(px);
            send_group(px, 1);
        end
        wait_done(600);
        check("delay_px2_addr", got_b[4].addr, 32'h0000_8010);
        check("delay_map2_addr", got_b[5].addr, 32'h0000_9008);
        compare_frame("delay");
        $display("three-group delayed-grant frame");

        // Randomized frames against the model.
        for (int f = 0; f < 6; f++) begin
            int ng;
            int dens;
            ng        = $urandom_range(1, 4);
            gnt_delay = $urandom_range(0, 4);
`ifdef SME_ZERO_THRESH_EN
            cfg_thresh = 8'($urandom_range(0, 200));
            model_thr  = cfg_thresh;
`endif
            start_frame($urandom, $urandom, 16'(ng));
            for (int g = 0; g < ng; g++) begin
                dens = $urandom_range(0, 100);
                for (int k = 0; k < G; k++)
                    px[k] = ($urandom_range(0, 99) < dens) ? 8'($urandom_range(0, 255)) : 8'h00;
                model_group(px);
                send_group(px, 3);
            end
            wait_done(200 * ng);
            compare_frame("rand");
            $display("random frame %0d groups=%0d", f, ng);
        end
        cfg_thresh = '0;
        model_thr  = '0;

        // Reset while a pixel request is pending, then a clean restart.
        gnt_delay = 0;
        gnt_block = 1'b1;
        start_frame(32'h5000, 32'h6000, 16'd2);
        for (int k = 0; k < G; k++) px[k] = 8'(k + 1);
        send_group(px, 0);
        begin
            int n;
            n = 0;
            while (!sif.mem_req && n <= 100) begin
                @(negedge clk);
                n++;
            end
            check("rst_test_req_seen", sif.mem_req, 1'b1);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_mem_req", sif.mem_req, 1'b0);
        check("midrst_wr_buf", sif.mem_wr_buf, 1'b0);
        check("midrst_addr_len_cmd", {sif.mem_addr, sif.mem_len, sif.mem_cmd}, 64'h0);
        check("midrst_busy_done_rdy", {busy, done, sif.din_rdy}, 3'b000);
        @(negedge clk);
        @(negedge clk);
        rst       = 1'b0;
        gnt_block = 1'b0;
        got_b.delete(); got_w.delete(); exp_b.delete(); exp_w.delete();
        start_frame(32'h0000_A000, 32'h0000_B000, 16'd1);
        beats_to_px(64'h0000_0300_0000_0005, 64'h0, px);
        model_group(px);
        send_group(px, 0);
        wait_done(200);
        compare_frame("post_rst");
        $display("mid-request reset and restart");

`ifdef SME_ZERO_THRESH_EN
        cfg_thresh = 8'd3;
        start_frame(32'h1000, 32'h2000, 16'd1);
        cfg_thresh = 8'd0;
        for (int k = 0; k < G; k++) px[k] = 8'h00;
        px[0] = 8'd3; px[1] = 8'd4; px[2] = 8'd0; px[3] = 8'd9;
        send_group(px, 0);
        wait_done(200);
        check("thr_px_word", got_w[0], 32'h0000_0904);
        check("thr_map_word", got_w[got_w.size() - 1], 32'h0000_000A);
        got_b.delete(); got_w.delete();
        $display("threshold frame");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

endmodule
